// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: occupancy state
// encoding and the default bubble word used when the stage is empty.
package pipe_pkg;

  // Occupancy state; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } stage_state_e;

  // Default payload width for the IF/ID instance ({pc, inst}).
  localparam int unsigned IFID_DATA_W = 64;

  // All-zero word, decoded downstream as a NOP.
  localparam logic [IFID_DATA_W-1:0] NOP_BUBBLE = '0;

endpackage : pipe_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Next count: step by one unless already at the all-ones ceiling.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer.
// The main entry drives the outputs; the skid entry absorbs the one
// item accepted while downstream stalls, so in_ready_o can come
// straight from a flop. Flush turns the stage into a bubble.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned        DATA_W = 64,
  parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
  parameter int unsigned        CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  stage_state_e      state_q;
  stage_state_e      state_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;

  logic main_v;
  logic skid_v;
  logic in_fire;
  logic out_fire;
  logic stall_inc;

  // Entry-valid flags and handshakes, all derived from registered state
  // except the upstream/downstream strobes themselves.
  always_comb begin
    main_v    = (state_q != ST_EMPTY);
    skid_v    = (state_q == ST_FULL);
    in_fire   = in_valid_i & ~skid_v;
    out_fire  = main_v & out_ready_i;
    stall_inc = main_v & ~out_ready_i & ~flush_i;
  end

  // State register; reset and flush both empty the stage.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: occupancy moves by +1 on in_fire, -1 on out_fire.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (in_fire) state_d = ST_ONE;
      ST_ONE: begin
        if (in_fire && !out_fire)      state_d = ST_FULL;
        else if (!in_fire && out_fire) state_d = ST_EMPTY;
      end
      ST_FULL:  if (out_fire) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
    end
  end

  // Payload steering. Data only loads on in_fire, so in_data_i is never
  // sampled while in_valid_i is low and X there cannot reach the outputs.
  always_comb begin
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    unique case (state_q)
      ST_EMPTY: if (in_fire) main_data_d = in_data_i;
      ST_ONE: begin
        if (in_fire && out_fire) main_data_d = in_data_i;
        else if (in_fire)        skid_data_d = in_data_i;
      end
      ST_FULL: begin
        if (out_fire) begin
          main_data_d = skid_data_q;
          skid_data_d = BUBBLE;
        end
      end
      default: begin
        main_data_d = BUBBLE;
        skid_data_d = BUBBLE;
      end
    endcase
    if (flush_i) begin
      main_data_d = BUBBLE;
      skid_data_d = BUBBLE;
    end
  end

  // Payload registers.
  always_ff @(posedge clk_i) begin
    // NOTE: the two data entries are reset too, so a bubble is visible even before the first flush.
    if (rst_i) begin
      main_data_q <= BUBBLE;
      skid_data_q <= BUBBLE;
    end else begin
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    out_valid_o = main_v;
    out_data_o  = main_v ? main_data_q : BUBBLE;
    in_ready_o  = ~skid_v;
    count_o     = state_q;
  end

  // Cycles spent presenting a payload that downstream does not take.
  sat_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stimulus pushes expected payloads
// into a queue; a negedge monitor pops and compares on every out_fire.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        count;
  logic [CNT_W-1:0]  stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] sb[$];
  bit                track_cnt = 1'b0;
  int                max_cnt   = 0;

  pipe_stage_reg #(
    .DATA_W (DATA_W),
    .BUBBLE (NOP_BUBBLE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .count_o     (count),
    .stall_cnt_o (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge, then settle before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    sb.push_back(d);
    tick();
    in_valid = 1'b0;
  endtask

  // Monitor: on every real out_fire, compare against the next expected payload.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_out: got %h expected nothing (t=%0t)", out_data, $time);
      end else begin
        check("out_data_order", out_data, sb.pop_front());
      end
    end
    if (track_cnt && int'(count) > max_cnt) max_cnt = int'(count);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 64'hDEAD; out_ready = 1'b0;

    // Reset held two edges with in_valid high.
    tick(); tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  out_data,       64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_count",     64'(count),     64'd0);
    check("rst_stall",     64'(stall_cnt), 64'd0);
    rst = 1'b0; in_valid = 1'b0;

    // X on in_data while not valid must not reach the output.
    in_data = 'x;
    tick();
    check("x_ignored_valid", 64'(out_valid), 64'd0);
    check("x_ignored_data",  out_data,       64'd0);

    // Streaming 1..8 with downstream always ready.
    out_ready = 1'b1;
    track_cnt = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      sb.push_back(64'(i));
      tick();
      if (i == 1) begin
        check("latency_valid", 64'(out_valid), 64'd1);
        check("latency_data",  out_data,       64'd1);
      end
    end
    in_valid = 1'b0;
    tick(); tick();
    track_cnt = 1'b0;
    check("stream_max_count", 64'(max_cnt), 64'd1);
    check("stream_drained",   64'(count),   64'd0);

    // Backpressure: 0xA, 0xB with downstream stalled.
    out_ready = 1'b0;
    send(64'hA);
    send(64'hB);
    check("bp_count",    64'(count),     64'd2);
    check("bp_in_ready", 64'(in_ready),  64'd0);
    check("bp_data",     out_data,       64'hA);
    check("bp_stall1",   64'(stall_cnt), 64'd1);
    tick();
    check("bp_stall2",   64'(stall_cnt), 64'd2);
    tick();
    check("bp_stall3",   64'(stall_cnt), 64'd3);
    check("bp_hold",     out_data,       64'hA);
    out_ready = 1'b1;
    tick();
    check("bp_ready_back", 64'(in_ready),  64'd1);
    check("bp_count_one",  64'(count),     64'd1);
    check("bp_second",     out_data,       64'hB);
    check("bp_stall_kept", 64'(stall_cnt), 64'd3);
    tick();
    check("bp_drained",    64'(count),     64'd0);

    // Flush with both entries full and a new payload offered.
    out_ready = 1'b0;
    send(64'hA);
    send(64'hB);
    in_valid = 1'b1; in_data = 64'hC; flush = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count",    64'(count),     64'd0);
    check("fl_valid",    64'(out_valid), 64'd0);
    check("fl_data",     out_data,       64'd0);
    check("fl_in_ready", 64'(in_ready),  64'd1);
    check("fl_stall",    64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    tick(); tick();
    check("fl_no_c",     64'(out_valid), 64'd0);

    // Saturation of the 4-bit stall counter.
    out_ready = 1'b0;
    send(64'h7);
    repeat (10) tick();
    check("sat_14", 64'(stall_cnt), 64'd14);
    repeat (10) tick();
    check("sat_15", 64'(stall_cnt), 64'd15);
    check("sat_hold_data", out_data, 64'h7);
    flush = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0;
    check("sat_after_flush", 64'(stall_cnt), 64'd15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("sat_after_rst", 64'(stall_cnt), 64'd0);

    // Simultaneous in_fire and out_fire in state ONE.
    out_ready = 1'b0;
    send(64'h5);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 64'h6;
    sb.push_back(64'h6);
    tick();
    in_valid = 1'b0;
    check("sim_count", 64'(count),     64'd1);
    check("sim_valid", 64'(out_valid), 64'd1);
    check("sim_data",  out_data,       64'h6);
    tick(); tick();
    check("sim_drained", 64'(count), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_pipe_stage_reg
